// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// A one-entry holding register allows back-to-back frames with no idle gap.
module uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned PARITY       = 0,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx,
   output logic       tx_busy
);

   localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_e;

   state_e        state_q, state_d;
   logic [BW-1:0] baud_cnt_q, baud_cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic          stop_idx_q, stop_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d;
   logic [7:0]    hold_q, hold_d;
   logic          hold_full_q, hold_full_d;
   logic          tx_q, tx_d;
   logic          busy_q, busy_d;

   logic          accept;
   logic          bit_end;
   logic          last_stop;
   logic          load_from_in;
   logic          load_from_hold;
   logic [7:0]    load_byte;

   assign tx_ready = ~hold_full_q;
   assign tx       = tx_q;
   assign tx_busy  = busy_q;

   always_comb begin
      state_d        = state_q;
      baud_cnt_d     = baud_cnt_q;
      bit_idx_d      = bit_idx_q;
      stop_idx_d     = stop_idx_q;
      shift_d        = shift_q;
      par_d          = par_q;
      hold_d         = hold_q;
      hold_full_d    = hold_full_q;
      tx_d           = tx_q;
      load_from_in   = 1'b0;
      load_from_hold = 1'b0;

      accept    = tx_valid & ~hold_full_q;
      bit_end   = (baud_cnt_q == BAUD_MAX);
      last_stop = (STOP_BITS == 1) || stop_idx_q;

      if (state_q != S_IDLE) begin
         baud_cnt_d = bit_end ? '0 : baud_cnt_q + 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (accept) load_from_in = 1'b1;
         end
         S_START: begin
            if (bit_end) begin
               state_d   = S_DATA;
               bit_idx_d = '0;
               tx_d      = shift_q[0];
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (bit_idx_q == 3'd7) begin
                  if (PARITY != 0) begin
                     state_d = S_PARITY;
                     tx_d    = par_q;
                  end else begin
                     state_d    = S_STOP;
                     stop_idx_d = 1'b0;
                     tx_d       = 1'b1;
                  end
               end else begin
                  shift_d   = {1'b0, shift_q[7:1]};
                  bit_idx_d = bit_idx_q + 3'd1;
                  tx_d      = shift_q[1];
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               state_d    = S_STOP;
               stop_idx_d = 1'b0;
               tx_d       = 1'b1;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               if (!last_stop) begin
                  stop_idx_d = 1'b1;
               end else if (hold_full_q) begin
                  load_from_hold = 1'b1;
               end else if (accept) begin
                  load_from_in = 1'b1;
               end else begin
                  state_d = S_IDLE;
                  tx_d    = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
         end
      endcase

      // A handshake that does not start a frame right away parks the byte in the holding register
      if (accept && !load_from_in) begin
         hold_d      = tx_data;
         hold_full_d = 1'b1;
      end
      if (load_from_hold) hold_full_d = 1'b0;

      load_byte = load_from_hold ? hold_q : tx_data;
      if (load_from_in || load_from_hold) begin
         state_d    = S_START;
         baud_cnt_d = '0;
         bit_idx_d  = '0;
         stop_idx_d = 1'b0;
         shift_d    = load_byte;
         par_d      = (PARITY == 2) ? ~(^load_byte) : ^load_byte;
         tx_d       = 1'b0;
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         baud_cnt_q  <= '0;
         bit_idx_q   <= '0;
         stop_idx_q  <= 1'b0;
         shift_q     <= '0;
         par_q       <= 1'b0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         tx_q        <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         baud_cnt_q  <= baud_cnt_d;
         bit_idx_q   <= bit_idx_d;
         stop_idx_q  <= stop_idx_d;
         shift_q     <= shift_d;
         par_q       <= par_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         tx_q        <= tx_d;
         busy_q      <= busy_d;
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx with CLKS_PER_BIT=4: 8N1, 8E1 and 8O2 instances.
module tb_uart_tx;

   typedef struct packed {
      logic [7:0] d;
      logic       p;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       vld [3];
   logic [7:0] dat [3];
   logic       rdy [3];
   logic       txl [3];
   logic       bsy [3];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int bcnt0 = 0, bcnt1 = 0, bcnt2 = 0;
   int nfr [3];
   int starts0 [$];
   exp_t sq0 [$], sq1 [$], sq2 [$];

   uart_tx #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .tx_data(dat[0]), .tx_valid(vld[0]),
      .tx_ready(rdy[0]), .tx(txl[0]), .tx_busy(bsy[0]));
   uart_tx #(.CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .tx_data(dat[1]), .tx_valid(vld[1]),
      .tx_ready(rdy[1]), .tx(txl[1]), .tx_busy(bsy[1]));
   uart_tx #(.CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .tx_data(dat[2]), .tx_valid(vld[2]),
      .tx_ready(rdy[2]), .tx(txl[2]), .tx_busy(bsy[2]));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (bsy[0] === 1'b1) bcnt0 <= bcnt0 + 1;
      if (bsy[1] === 1'b1) bcnt1 <= bcnt1 + 1;
      if (bsy[2] === 1'b1) bcnt2 <= bcnt2 + 1;
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
      end
   endtask

   function automatic int busy_count(input int id);
      case (id)
         0: return bcnt0;
         1: return bcnt1;
         default: return bcnt2;
      endcase
   endfunction

   function automatic int qsize(input int id);
      case (id)
         0: return sq0.size();
         1: return sq1.size();
         default: return sq2.size();
      endcase
   endfunction

   function automatic exp_t qpop(input int id);
      exp_t e;
      e = '0;
      case (id)
         0: if (sq0.size() > 0) e = sq0.pop_front();
         1: if (sq1.size() > 0) e = sq1.pop_front();
         default: if (sq2.size() > 0) e = sq2.pop_front();
      endcase
      return e;
   endfunction

   task automatic qpush(input int id, input exp_t e);
      case (id)
         0: sq0.push_back(e);
         1: sq1.push_back(e);
         default: sq2.push_back(e);
      endcase
   endtask

   // Watches one serial line; on a start bit pops the expected frame and checks every cycle.
   task automatic mon(input int id, input int npar, input int nstop);
      int nbits;
      nbits = 9 + npar + nstop;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && txl[id] === 1'b0) begin
            exp_t       e;
            logic [11:0] ev;
            logic [7:0] got;
            logic       gotp;
            int         badc;
            logic       abort;
            if (id == 0) starts0.push_back(cyc);
            if (qsize(id) == 0) chk($sformatf("unexpected_frame%0d", id), 1, 0);
            e = qpop(id);
            ev = '1;
            ev[0] = 1'b0;
            ev[8:1] = e.d;
            if (npar != 0) ev[9] = e.p;
            got = '0; gotp = 1'b0; badc = 0; abort = 1'b0;
            for (int c = 0; c < nbits * 4; c++) begin
               if (c > 0) @(negedge clk);
               if (rst_n !== 1'b1) begin
                  abort = 1'b1;
                  break;
               end
               if (txl[id] !== ev[c/4] || bsy[id] !== 1'b1) badc++;
               if (c % 4 == 2) begin
                  if (c/4 >= 1 && c/4 <= 8) got[c/4-1] = txl[id];
                  if (npar != 0 && c/4 == 9) gotp = txl[id];
               end
            end
            if (!abort) begin
               nfr[id]++;
               chk($sformatf("data%0d", id), got, e.d);
               if (npar != 0) chk($sformatf("parity%0d", id), gotp, e.p);
               chk($sformatf("wave_bad_cycles%0d", id), badc, 0);
            end
         end
      end
   endtask

   task automatic send(input int id, input logic [7:0] b, input logic p,
                       output int acc, output int waits);
      exp_t e;
      e.d = b; e.p = p;
      qpush(id, e);
      @(negedge clk);
      vld[id] = 1'b1;
      dat[id] = b;
      waits = 0;
      while (rdy[id] !== 1'b1 && waits < 500) begin
         @(negedge clk);
         waits++;
      end
      if (waits >= 500) begin
         chk("handshake_timeout", 1, 0);
         vld[id] = 1'b0;
         acc = -1;
      end else begin
         @(posedge clk);
         #1;
         acc = cyc;
         vld[id] = 1'b0;
      end
   endtask

   task automatic wait_idle(input int id);
      int n;
      n = 0;
      while (bsy[id] !== 1'b0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) chk("idle_timeout", 1, 0);
   endtask

   initial begin
      int a1, a2, a3, w, b0;
      int quiet;
      for (int i = 0; i < 3; i++) begin
         vld[i] = 1'b0;
         dat[i] = 8'h00;
         nfr[i] = 0;
      end
      fork
         mon(0, 0, 1);
         mon(1, 1, 1);
         mon(2, 1, 2);
      join_none

      #2 rst_n = 1'b0;
      #1;
      chk("reset_tx", txl[0], 1);
      chk("reset_busy", bsy[0], 0);
      chk("reset_ready", rdy[0], 1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // single 0x55, 8N1
      b0 = busy_count(0);
      send(0, 8'h55, 1'b0, a1, w);
      wait_idle(0);
      chk("busy_55", busy_count(0) - b0, 40);
      chk("latency_55", starts0[starts0.size()-1] - a1, 0);
      repeat (3) @(negedge clk);

      // back-to-back 0xA5, 0x3C and backpressured 0xFF
      b0 = busy_count(0);
      send(0, 8'hA5, 1'b0, a1, w);
      send(0, 8'h3C, 1'b0, a2, w);
      chk("accept2_gap", a2 - a1, 1);
      chk("ready_low_when_full", rdy[0], 0);
      send(0, 8'hFF, 1'b0, a3, w);
      chk("ready_low_cycles", w, 39);
      chk("accept3_after_transfer", a3 - a1, 41);
      wait_idle(0);
      chk("busy_b2b", busy_count(0) - b0, 120);
      chk("gap_frame2", starts0[starts0.size()-2] - starts0[starts0.size()-3], 40);
      chk("gap_frame3", starts0[starts0.size()-1] - starts0[starts0.size()-2], 40);
      chk("idle_tx", txl[0], 1);

      // parity: even parity of 0x07 is 1, odd is 0; 0x03 gives the opposite
      b0 = busy_count(1);
      send(1, 8'h07, 1'b1, a1, w);
      wait_idle(1);
      chk("busy_8e1", busy_count(1) - b0, 44);
      b0 = busy_count(2);
      send(2, 8'h07, 1'b0, a1, w);
      wait_idle(2);
      chk("busy_8o2", busy_count(2) - b0, 48);
      send(1, 8'h03, 1'b0, a1, w);
      send(2, 8'h03, 1'b1, a2, w);
      wait_idle(1);
      wait_idle(2);

      // reset mid-frame with a byte held
      send(0, 8'hC3, 1'b0, a1, w);
      send(0, 8'h81, 1'b0, a2, w);
      repeat (10) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midreset_tx", txl[0], 1);
      chk("midreset_busy", bsy[0], 0);
      chk("midreset_ready", rdy[0], 1);
      @(negedge clk);
      @(negedge clk);
      sq0.delete();
      rst_n = 1'b1;
      quiet = 0;
      repeat (20) begin
         @(negedge clk);
         if (txl[0] !== 1'b1 || bsy[0] !== 1'b0) quiet++;
      end
      chk("quiet_after_reset", quiet, 0);
      b0 = busy_count(0);
      send(0, 8'h12, 1'b0, a1, w);
      wait_idle(0);
      chk("busy_12", busy_count(0) - b0, 40);
      repeat (60) @(negedge clk);

      chk("frames0", nfr[0], 5);
      chk("frames1", nfr[1], 2);
      chk("frames2", nfr[2], 2);
      chk("leftover0", sq0.size(), 0);
      chk("leftover1", sq1.size(), 0);
      chk("leftover2", sq2.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
